// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// A shift-add multiplier and a restoring divider share one accumulator pair and
// run one bit per cycle under a small IDLE/CALC/FIX/DONE controller.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start, flush  operation request (sampled in IDLE only); pipeline abort
//   func3         RV32M operation select (MUL..REMU)
//   op_a, op_b    rs1 / rs2 operand values, latched on acceptance
//   busy          high whenever the unit is not idle (including DONE)
//   done          one-cycle pulse, result valid in that cycle
//   result        rd value, held until replaced by the next completed operation
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] md_q, md_d;    // multiplicand / divisor magnitude
  logic [XLEN-1:0] acc_q, acc_d;  // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;    // product low half (multiplier) / quotient (dividend)
  logic [XLEN-1:0] result_d;
  logic            busy_d, done_d;

  // Operand sign handling at acceptance
  logic            a_signed, b_signed, a_neg, b_neg, in_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  assign a_signed = (func3 == F_MULH) || (func3 == F_MULHSU) ||
                    (func3 == F_DIV)  || (func3 == F_REM);
  assign b_signed = (func3 == F_MULH) || (func3 == F_DIV) || (func3 == F_REM);
  assign a_neg    = a_signed & op_a[XLEN-1];
  assign b_neg    = b_signed & op_b[XLEN-1];
  assign a_mag    = a_neg ? (XLEN'(0) - op_a) : op_a;
  assign b_mag    = b_neg ? (XLEN'(0) - op_b) : op_b;
  assign in_div   = func3[2];
  assign div_zero = in_div && (op_b == '0);
  // Signed overflow applies to DIV and REM only (func3[0]==0 within the divide group)
  assign div_ovf  = in_div && !func3[0] && (op_a == MIN_NEG) && (op_b == '1);

  // One multiply iteration: conditional add then shift the 2*XLEN product right
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, md_q} : {(XLEN+1){1'b0}});

  // One restoring divide iteration; trial[XLEN] set means the subtract borrowed
  logic [XLEN:0] div_shift, div_trial;
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, md_q};

  // Sign fix-up and output select
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_val;
  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_q ? (PW'(0) - prod) : prod;
  assign quo_s  = neg_q ? (XLEN'(0) - lo_q) : lo_q;
  assign rem_s  = neg_q ? (XLEN'(0) - acc_q) : acc_q;

  always_comb begin
    case (f3_q)
      F_MUL:                    fix_val = prod_s[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_val = prod_s[PW-1:XLEN];
      default:                  fix_val = f3_q[1] ? rem_s : quo_s;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      md_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      md_q    <= md_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      result  <= result_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    md_d     = md_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    result_d = result;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d  = func3;
          md_d  = b_mag;
          lo_d  = a_mag;
          acc_d = '0;
          cnt_d = CW'(XLEN - 1);
          // Remainder takes the dividend's sign; everything else a^b
          neg_d = (in_div && func3[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            result_d = func3[1] ? op_a : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = func3[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (f3_q[2]) begin
          acc_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], ~div_trial[XLEN]};
        end else begin
          {acc_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts anything in flight and keeps the previous result
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M vectors, randomized
// operations against an arithmetic reference model, flush, ignored starts and
// asynchronous reset mid-operation.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .func3(func3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Issue one operation and wait (bounded) for done; operands are scrambled after acceptance
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat     = 999;
    res     = 'x;
    start = 1'b1; func3 = f3; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    for (int n = 1; n <= 100; n++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = n;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, exp_res;
    int lat, exp_lat;
    bit bok;
    exp_res = model(f3, a, b);
    exp_lat = model_lat(f3, a, b);
    run_op(f3, a, b, res, lat, bok);
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s result f3=%0d a=%h b=%h got=%h exp=%h", name, f3, a, b, res, exp_res);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency f3=%0d got=%0d exp=%0d", name, f3, lat, exp_lat);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy dropped before/at done f3=%0d", name, f3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result} !== 34'h0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b result=%h exp=0/0/0", busy, done, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op("T1_mul",    3'd0, 32'd7,          32'hFFFF_FFFD);
    checks++;
    if (result !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL T1_const result got=%h exp=%h", result, 32'hFFFF_FFEB);
    end
    check_op("T2_mulh",   3'd1, 32'h8000_0000,  32'h8000_0000);
    check_op("T2_mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    check_op("T2_mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2);
    check_op("T3_div",    3'd4, 32'hFFFF_FFF9,  32'd2);
    check_op("T3_rem",    3'd6, 32'hFFFF_FFF9,  32'd2);
    check_op("T3_divu",   3'd5, 32'd100,        32'd7);
    checks++;
    if (result !== 32'd14) begin
      errors++;
      $display("FAIL T3_divu_const got=%h exp=%h", result, 32'd14);
    end
    check_op("T3_remu",   3'd7, 32'd100,        32'd7);
    check_op("T4_div0",   3'd4, 32'd5,          32'd0);
    check_op("T4_remu0",  3'd7, 32'd5,          32'd0);
    check_op("T4_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    check_op("T4_removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    check_op("T4_divu0",  3'd5, 32'h1234_5678,  32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      check_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int lat;
    bit bok, seen;
    prev = result;
    start = 1'b1; func3 = 3'd0; op_a = 32'd123; op_b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || result !== prev) begin
      errors++;
      $display("FAIL flush busy=%b done=%b result=%h exp busy=0 done=0 result=%h", busy, done, result, prev);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || result !== prev) begin
      errors++;
      $display("FAIL flush_aftermath activity=%b result=%h exp activity=0 result=%h", seen, result, prev);
    end
    // flush together with start in IDLE is not accepted
    start = 1'b1; flush = 1'b1; func3 = 3'd5; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_idle busy=%b exp=0", busy);
    end
    // flush in the FIX cycle suppresses the done that would follow
    start = 1'b1; func3 = 3'd5; op_a = 32'd90; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || result !== prev) begin
      errors++;
      $display("FAIL flush_fix busy=%b done=%b result=%h exp 0/0/%h", busy, done, result, prev);
    end
    run_op(3'd5, 32'd90, 32'd9, res, lat, bok);
    checks++;
    if (res !== 32'd10 || lat !== 34) begin
      errors++;
      $display("FAIL flush_restart result=%h lat=%0d exp=%h/34", res, lat, 32'd10);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic [31:0] exp_res;
    bit got;
    exp_res = model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    start = 1'b1; func3 = 3'd1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin got = 1'b1; break; end
      // Stray requests while busy must be ignored
      start = (n % 3 == 0); func3 = 3'd4; op_a = $urandom; op_b = 32'd0;
      @(posedge clk); #1;
    end
    checks++;
    if (got !== 1'b1 || result !== exp_res) begin
      errors++;
      $display("FAIL busy_start got_done=%b result=%h exp=%h", got, result, exp_res);
    end
    // start on the done cycle is ignored
    start = 1'b1; func3 = 3'd4; op_a = 32'd5; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || result !== exp_res) begin
      errors++;
      $display("FAIL done_start busy=%b done=%b result=%h exp 0/0/%h", busy, done, result, exp_res);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL done_start_late busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_rst_mid();
    bit seen;
    start = 1'b1; func3 = 3'd0; op_a = 32'd77; op_b = 32'd88;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result} !== 34'h0) begin
      errors++;
      $display("FAIL async_rst busy=%b done=%b result=%h exp 0/0/0", busy, done, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy || result != 0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_aftermath activity=%b exp=0", seen);
    end
    check_op("post_rst", 3'd6, 32'hFFFF_FF9C, 32'd7);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_ignore_start();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
